instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: word-addressed PC, on-chip instruction memory
// that is written through the program-load port, and one registered
// instruction/PC pair handed to the decoder.
// Optional feature: define IFETCH_HALT_EN to stop fetching after a word
// whose opcode field [31:26] is 6'd63.
module instruction_fetch #(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   pc,
  output logic [31:0]   instruction,
  output logic          instr_valid,
  output logic          halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] rd_word;

  logic [31:0] imem_q [IMEM_DEPTH];

  // Program-load writes; a redirect or an active reset cancels the write.
  always_ff @(posedge clk) begin
    if (load_en && !redirect && !rst) begin
      imem_q[load_addr] <= load_data;
    end
  end

  // Combinational read at the fetch pointer; upper PC bits do not index.
  always_comb begin
    rd_word = imem_q[fpc_q[AW-1:0]];
  end

  // Next-state and fetch control: redirect, then stall, then load, then halt.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      fpc_d   = redirect_pc;
      instr_d = 32'd0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (stall) begin
      // Everything holds; a concurrent load still writes memory.
    end else if (load_en) begin
      valid_d = 1'b0;
    end else if (state_q == HALT) begin
      valid_d = 1'b0;
    end else begin
      instr_d = rd_word;
      pc_d    = fpc_q;
      valid_d = 1'b1;
      fpc_d   = fpc_q + 32'd1;
`ifdef IFETCH_HALT_EN
      if (rd_word[31:26] == 6'd63) begin
        state_d = HALT;
      end
`endif
    end
  end

  // Control and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fpc_q   <= 32'd0;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
`ifdef IFETCH_HALT_EN
  assign halted      = (state_q == HALT);
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, redirect,
// index and 32-bit wrap, program load, reset behaviour and the opcode-63
// word with or without IFETCH_HALT_EN.
module tb_instruction_fetch;

  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [31:0]   pc;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch #(.IMEM_DEPTH(64), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .pc          (pc),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic e_vld, input logic e_hlt);
    chk({tag, ".pc"},     pc,                   e_pc);
    chk({tag, ".instr"},  instruction,          e_ins);
    chk({tag, ".valid"},  {31'd0, instr_valid}, {31'd0, e_vld});
    chk({tag, ".halted"}, {31'd0, halted},      {31'd0, e_hlt});
  endtask

  function automatic logic [31:0] img(input int i);
    case (i)
      0:       img = 32'h0822_1800;
      1:       img = 32'h0C64_2000;
      2:       img = 32'h10A5_3000;
      3:       img = 32'hFC00_0000;
      default: img = 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    load_en = 1'b0; load_addr = '0; load_data = 32'd0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk_out("reset", 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    step();

    // Program the memory through the load port
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = img(i);
      step();
      if (i == 5) chk_out("load_init", 32'd0, 32'd0, 1'b0, 1'b0);
    end
    load_en = 1'b0;

    // Reset again; a write attempted under reset must be discarded
    rst = 1'b1;
    #1;
    chk_out("reset2", 32'd0, 32'd0, 1'b0, 1'b0);
    load_en = 1'b1; load_addr = AW'(2); load_data = 32'h0000_0BAD;
    step();
    load_en = 1'b0;
    rst = 1'b0;

    // Sequential fetch from 0
    step(); chk_out("seq0", 32'd0, 32'h0822_1800, 1'b1, 1'b0);
    step(); chk_out("seq1", 32'd1, 32'h0C64_2000, 1'b1, 1'b0);

    // Stall two cycles holds pc=1
    stall = 1'b1;
    step(); chk_out("stall_a", 32'd1, 32'h0C64_2000, 1'b1, 1'b0);
    step(); chk_out("stall_b", 32'd1, 32'h0C64_2000, 1'b1, 1'b0);
    stall = 1'b0;
    step(); chk_out("seq2", 32'd2, 32'h10A5_3000, 1'b1, 1'b0);

    // Opcode-63 word at index 3
    step();
`ifdef IFETCH_HALT_EN
    chk_out("halt_fetch", 32'd3, 32'hFC00_0000, 1'b1, 1'b1);
    step(); chk_out("halt_hold1", 32'd3, 32'hFC00_0000, 1'b0, 1'b1);
    step(); chk_out("halt_hold2", 32'd3, 32'hFC00_0000, 1'b0, 1'b1);
    redirect = 1'b1; redirect_pc = 32'd0;
    step(); chk_out("halt_redir", 32'd3, 32'd0, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); chk_out("halt_resume", 32'd0, 32'h0822_1800, 1'b1, 1'b0);
`else
    chk_out("op63_fetch", 32'd3, 32'hFC00_0000, 1'b1, 1'b0);
    step(); chk_out("op63_next", 32'd4, 32'hA500_0004, 1'b1, 1'b0);
`endif

    // Redirect wins over stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    step();
    chk("redir.valid", {31'd0, instr_valid}, 32'd0);
    chk("redir.instr", instruction, 32'd0);
    stall = 1'b0; redirect = 1'b0;
    step(); chk_out("redir_fetch", 32'h20, 32'hA500_0020, 1'b1, 1'b0);

    // Index wrap 63 -> 64 reads imem[0]
    redirect = 1'b1; redirect_pc = 32'd63;
    step();
    redirect = 1'b0;
    step(); chk_out("wrap63", 32'd63, 32'hA500_003F, 1'b1, 1'b0);
    step(); chk_out("wrap64", 32'd64, 32'h0822_1800, 1'b1, 1'b0);

    // Program load mid-run, then fetch the loaded word
    load_en = 1'b1; load_addr = AW'(5); load_data = 32'hDEAD_BEEF;
    step(); chk_out("load", 32'd64, 32'h0822_1800, 1'b0, 1'b0);
    load_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'd5;
    step();
    redirect = 1'b0;
    step(); chk_out("load_fetch", 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // 32-bit PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    step(); chk_out("pcmax", 32'hFFFF_FFFF, 32'hA500_003F, 1'b1, 1'b0);
    step(); chk_out("pcwrap", 32'd0, 32'h0822_1800, 1'b1, 1'b0);

    // Asynchronous reset acts without a clock edge
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step(); chk_out("post_rst", 32'd0, 32'h0822_1800, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
